picorv32_pcpi_mux: RTL and testbench
====================================

Name: picorv32_pcpi_mux

Overview:
Routes one PCPI request from the core to NUM_CP co-processors (slot 0 = divider, slot 1 = multiplier) and returns the owning co-processor's result. It sits between the core's PCPI port and the co-processors' PCPI ports. It broadcasts the request and claims an owner from the first `cp_wait` or `cp_ready`. It registers the owner's response back to the core and times out requests that no co-processor claims. It also forces a one-cycle valid-low gap after every completion, so co-processors that gate decode on `!pcpi_ready` never re-trigger.

Parameters:
- NUM_CP, 2, number of co-processor slots; legal range 1..8.
- TIMEOUT, 16, CLAIM cycles without any `cp_wait`/`cp_ready` before the request is rejected; legal range 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pcpi_valid  in  1  core request; held high until `pcpi_ready` or abort.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  result valid for rd write; pulses with `pcpi_ready`.
- pcpi_rd  out  32  result.
- pcpi_wait  out  1  owner busy.
- pcpi_ready  out  1  one-cycle completion pulse.
- pcpi_timeout  out  1  one-cycle pulse: request unclaimed, core traps illegal-insn.
- pcpi_conflict  out  1  one-cycle pulse: more than one slot claimed in the same cycle.
- cp_valid  out  1  broadcast valid to all slots.
- cp_insn  out  32  broadcast insn; combinational pass-through.
- cp_rs1  out  32  broadcast rs1; combinational pass-through.
- cp_rs2  out  32  broadcast rs2; combinational pass-through.
- cp_wr  in  NUM_CP  per-slot wr.
- cp_rd  in  32*NUM_CP  per-slot rd; slot i occupies bits [32i+31:32i].
- cp_wait  in  NUM_CP  per-slot wait.
- cp_ready  in  NUM_CP  per-slot ready.

Behaviour:
- Reset: state=IDLE, owner=0, counter=0.
- Reset: `pcpi_wr`, `pcpi_ready`, `pcpi_wait`, `pcpi_timeout`, `pcpi_conflict` = 0; `pcpi_rd` = 0.
- Reset mid-operation abandons the request; all outputs are 0 the cycle after reset is sampled.
- `cp_valid` = `pcpi_valid` && state in {CLAIM, BUSY}; combinational. All other outputs are registered.
- IDLE: when `pcpi_valid`=1, go to CLAIM and clear the counter.
- CLAIM, claim rule: claim = `cp_wait` | `cp_ready`.
  - If any claim bit is set, owner = lowest set index; `pcpi_conflict` pulses if more than one bit is set.
  - If the owner's ready=1, capture the response (see RESP) and go to DRAIN.
  - Otherwise go to BUSY.
- CLAIM, no claim: counter++. When counter reaches TIMEOUT-1, pulse `pcpi_timeout` and go to DRAIN.
- BUSY:
  - `pcpi_wait` <= `cp_wait[owner]`.
  - On `cp_ready[owner]`, capture the response and go to DRAIN.
  - Non-owner `cp_ready`/`cp_wait` are ignored in BUSY and DRAIN.
- RESP capture, applied next cycle:
  - `pcpi_ready`=1, `pcpi_wr` = `cp_wr[owner]`, `pcpi_rd` = `cp_rd[owner]`, `pcpi_wait`=0.
  - Latency: `cp_ready` at cycle t gives `pcpi_ready` at t+1.
  - `pcpi_rd` returns to 0 on every cycle without a ready pulse.
- DRAIN: exactly one cycle with `cp_valid`=0, then IDLE. A back-to-back request therefore reaches the co-processors at the earliest 2 cycles after `pcpi_ready`.
- Abort: `pcpi_valid` falls in CLAIM or BUSY → DRAIN, no `pcpi_ready`, owner response discarded.
- Simultaneous abort and owner ready in the same cycle: the response is delivered.
- Width rules:
  - Owner index is clog2(NUM_CP) bits, minimum 1.
  - Counter is 8 bits and saturates; no wrap.

Decomposition:
- Package picorv32_pcpi_pkg holds:
  - the state enum {IDLE, CLAIM, BUSY, DRAIN};
  - PCPI_W=32;
  - slot constants CP_DIV=0, CP_MUL=1;
  - the opcode constants 7'b0110011 and funct7 7'b0000001 for bench use.
- One sub-module is natural: picorv32_pcpi_prio_enc, the lowest-index one-hot encoder producing {any, index, multi}.

Test Plan:
- DIVU: rs1=100, rs2=7. Slot-0 model waits 34 cycles. Expected: one `pcpi_ready` pulse, `pcpi_wr`=1, `pcpi_rd`=14, `pcpi_wait`=1 throughout BUSY, `cp_valid`=0 the cycle after the ready pulse.
- Unclaimed insn 32'h0000_0033 (ADD): no slot claims. Expected: `pcpi_timeout` pulses exactly TIMEOUT=16 cycles after CLAIM entry, no `pcpi_ready`, state back to IDLE.
- Conflict: slots 0 and 1 both assert `cp_wait` in the same cycle. Expected: owner=0, `pcpi_conflict` pulses once, slot-1 `cp_ready` with rd=32'hDEAD is ignored, slot-0 rd=32'h1234 is returned.
- Single-cycle slot: slot 1 asserts `cp_ready` in its first CLAIM cycle with rd=32'hFFFF_FFFF, wr=1. Expected: `pcpi_ready` the next cycle, `pcpi_wait` never set.
- Abort: `pcpi_valid` drops after 5 BUSY cycles. Expected: no `pcpi_ready`. A new DIV with rs1=-20, rs2=3 issued 2 cycles later returns `pcpi_rd`=32'hFFFF_FFFA.
- Reset asserted mid-BUSY for 1 cycle. Expected: all outputs 0 next cycle, state IDLE, a late slot `cp_ready` is ignored.

Source files
------------

// File: rtl/picorv32_pcpi_pkg.sv
// Shared types and constants for the PCPI co-processor mux.
// Slot numbering and RV32M encodings used by the mux and its bench.
package picorv32_pcpi_pkg;

    localparam int PCPI_W = 32;

    localparam int CP_DIV = 0;
    localparam int CP_MUL = 1;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        CLAIM,
        BUSY,
        DRAIN
    } state_t;

endpackage

// File: rtl/picorv32_pcpi_prio_enc.sv
// Lowest-index priority encoder for co-processor claim bits.
// Reports whether any bit is set, its index, and whether several are.
module picorv32_pcpi_prio_enc #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_any,
    output logic [IW-1:0] o_idx,
    output logic          o_multi
);

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any   = |i_req;
    assign o_multi = |(i_req & (i_req - N'(1)));

endmodule

// File: rtl/picorv32_pcpi_mux.sv
// PCPI request router: broadcasts to co-processor slots, claims an owner,
// registers its response, times out unclaimed requests.
module picorv32_pcpi_mux
    import picorv32_pcpi_pkg::*;
#(
    parameter int NUM_CP  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pcpi_valid,
    input  logic [PCPI_W-1:0]        pcpi_insn,
    input  logic [PCPI_W-1:0]        pcpi_rs1,
    input  logic [PCPI_W-1:0]        pcpi_rs2,
    output logic                     pcpi_wr,
    output logic [PCPI_W-1:0]        pcpi_rd,
    output logic                     pcpi_wait,
    output logic                     pcpi_ready,
    output logic                     pcpi_timeout,
    output logic                     pcpi_conflict,
    output logic                     cp_valid,
    output logic [PCPI_W-1:0]        cp_insn,
    output logic [PCPI_W-1:0]        cp_rs1,
    output logic [PCPI_W-1:0]        cp_rs2,
    input  logic [NUM_CP-1:0]        cp_wr,
    input  logic [PCPI_W*NUM_CP-1:0] cp_rd,
    input  logic [NUM_CP-1:0]        cp_wait,
    input  logic [NUM_CP-1:0]        cp_ready
);

    localparam int IW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              r_state, w_state;
    logic [IW-1:0]       r_owner, w_owner;
    logic [7:0]          r_cnt, w_cnt;
    logic                r_ready, w_ready;
    logic                r_wr, w_wr;
    logic [PCPI_W-1:0]   r_rd, w_rd;
    logic                r_wait, w_wait;
    logic                r_timeout, w_timeout;
    logic                r_conflict, w_conflict;

    logic [NUM_CP-1:0]   w_claim;
    logic                w_any;
    logic                w_multi;
    logic [IW-1:0]       w_idx;
    logic [IW-1:0]       w_sel;
    logic                w_sel_rdy;
    logic                w_sel_wait;
    logic                w_sel_wr;
    logic [PCPI_W-1:0]   w_sel_rd;

    assign w_claim = cp_wait | cp_ready;

    picorv32_pcpi_prio_enc #(
        .N  (NUM_CP),
        .IW (IW)
    ) u_enc (
        .i_req   (w_claim),
        .o_any   (w_any),
        .o_idx   (w_idx),
        .o_multi (w_multi)
    );

    // In CLAIM the owner is not registered yet, so look at the encoder.
    assign w_sel = (r_state == CLAIM) ? w_idx : r_owner;

    always_comb begin
        w_sel_rdy  = 1'b0;
        w_sel_wait = 1'b0;
        w_sel_wr   = 1'b0;
        w_sel_rd   = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (IW'(i) == w_sel) begin
                w_sel_rdy  = cp_ready[i];
                w_sel_wait = cp_wait[i];
                w_sel_wr   = cp_wr[i];
                w_sel_rd   = cp_rd[PCPI_W*i +: PCPI_W];
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_cnt      = r_cnt;
        w_ready    = 1'b0;
        w_wr       = 1'b0;
        w_rd       = '0;
        w_wait     = 1'b0;
        w_timeout  = 1'b0;
        w_conflict = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (pcpi_valid) begin
                    w_state = CLAIM;
                    w_cnt   = '0;
                end
            end
            CLAIM: begin
                if (w_any) begin
                    w_owner    = w_idx;
                    w_conflict = w_multi;
                    if (w_sel_rdy) begin
                        w_ready = 1'b1;
                        w_wr    = w_sel_wr;
                        w_rd    = w_sel_rd;
                        w_state = DRAIN;
                    end else if (!pcpi_valid) begin
                        w_state = DRAIN;
                    end else begin
                        w_wait  = w_sel_wait;
                        w_state = BUSY;
                    end
                end else if (!pcpi_valid) begin
                    w_state = DRAIN;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_state   = DRAIN;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            BUSY: begin
                // A ready coinciding with abort still delivers.
                if (w_sel_rdy) begin
                    w_ready = 1'b1;
                    w_wr    = w_sel_wr;
                    w_rd    = w_sel_rd;
                    w_state = DRAIN;
                end else if (!pcpi_valid) begin
                    w_state = DRAIN;
                end else begin
                    w_wait = w_sel_wait;
                end
            end
            DRAIN: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= '0;
            r_wait     <= 1'b0;
            r_timeout  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_cnt      <= w_cnt;
            r_ready    <= w_ready;
            r_wr       <= w_wr;
            r_rd       <= w_rd;
            r_wait     <= w_wait;
            r_timeout  <= w_timeout;
            r_conflict <= w_conflict;
        end
    end

    assign cp_valid = pcpi_valid && ((r_state == CLAIM) || (r_state == BUSY));
    assign cp_insn  = pcpi_insn;
    assign cp_rs1   = pcpi_rs1;
    assign cp_rs2   = pcpi_rs2;

    assign pcpi_ready    = r_ready;
    assign pcpi_wr       = r_wr;
    assign pcpi_rd       = r_rd;
    assign pcpi_wait     = r_wait;
    assign pcpi_timeout  = r_timeout;
    assign pcpi_conflict = r_conflict;

endmodule

// File: tb/tb_picorv32_pcpi_mux.sv
// Scoreboard bench for picorv32_pcpi_mux with RV32M reference model.
module tb_picorv32_pcpi_mux;
    import picorv32_pcpi_pkg::*;

    localparam int NCP = 2;
    localparam int TO  = 16;

    typedef struct packed {
        logic        to;
        logic        wr;
        logic [31:0] rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic            pcpi_wr, pcpi_wait, pcpi_ready;
    logic            pcpi_timeout, pcpi_conflict;
    logic [31:0]     pcpi_rd;
    logic            cp_valid;
    logic [31:0]     cp_insn, cp_rs1, cp_rs2;
    logic [NCP-1:0]  cp_wr, cp_wait, cp_ready;
    logic [32*NCP-1:0] cp_rd;

    picorv32_pcpi_mux #(.NUM_CP(NCP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .pcpi_timeout(pcpi_timeout), .pcpi_conflict(pcpi_conflict),
        .cp_valid(cp_valid), .cp_insn(cp_insn),
        .cp_rs1(cp_rs1), .cp_rs2(cp_rs2),
        .cp_wr(cp_wr), .cp_rd(cp_rd),
        .cp_wait(cp_wait), .cp_ready(cp_ready)
    );

    always #5 clk = ~clk;

    exp_t q_exp[$];
    exp_t em, es;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_conf  = 0;
    int   c0, n;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {F7_MULDIV, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
    endfunction

    function automatic int slot_of(input logic [2:0] f3);
        return f3[2] ? CP_DIV : CP_MUL;
    endfunction

    function automatic logic [31:0] ref_muldiv(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sbv, ub;
        longint unsigned ua, ubu;
        logic [63:0] p;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ua  = {32'h0, a};
        ubu = {32'h0, b};
        r   = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sbv); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sbv); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ubu); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sbv);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = 32'(sa % sbv);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic cp_idle();
        cp_wait  = '0;
        cp_ready = '0;
        cp_wr    = '0;
        cp_rd    = '0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input bit noise);
        int s, o, wcnt;
        logic [31:0] res;
        exp_t e;
        s = slot_of(f3);
        o = 1 - s;
        res = ref_muldiv(f3, a, b);
        e.to = 1'b0;
        e.wr = 1'b1;
        e.rd = res;
        q_exp.push_back(e);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(f3);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        step();
        chk("claim_cp_valid", 32'(cp_valid), 1);
        chk("rs1_pass", cp_rs1, a);
        wcnt = 0;
        for (int c = 0; c <= lat; c++) begin
            cp_idle();
            if (c == lat) begin
                cp_ready[s] = 1'b1;
                cp_wr[s] = 1'b1;
                cp_rd[32*s +: 32] = res;
            end else begin
                cp_wait[s] = 1'b1;
            end
            if (noise && c > 0) begin
                cp_wait[o]  = 1'($urandom_range(0, 1));
                cp_ready[o] = 1'($urandom_range(0, 1));
                cp_wr[o]    = 1'b1;
                cp_rd[32*o +: 32] = 32'hDEAD_BEEF;
            end
            step();
            if (c < lat && pcpi_wait) wcnt++;
        end
        chk("wait_cycles", wcnt, lat);
        chk("drain_gap", 32'(cp_valid), 0);
        chk("drain_wait", 32'(pcpi_wait), 0);
        cp_idle();
        pcpi_valid = 1'b0;
        step();
        chk("sb_empty", q_exp.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pcpi_valid = 1'b1;
        pcpi_insn = '0;
        pcpi_rs1 = '0;
        pcpi_rs2 = '0;
        cp_idle();
        repeat (3) step();
        chk("rst_outs", 32'({pcpi_ready, pcpi_wr, pcpi_wait,
                             pcpi_timeout, pcpi_conflict}), 0);
        chk("rst_rd", pcpi_rd, 0);
        chk("rst_cp_valid", 32'(cp_valid), 0);
        pcpi_valid = 1'b0;
        reset = 1'b0;
        step();

        fork
            forever begin
                @(negedge clk);
                if (pcpi_conflict) n_conf++;
                n_tests++;
                if (pcpi_ready || pcpi_timeout) begin
                    if (q_exp.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected ready=%b timeout=%b rd=%h exp none",
                                 pcpi_ready, pcpi_timeout, pcpi_rd);
                    end else begin
                        em = q_exp.pop_front();
                        if ({pcpi_timeout, pcpi_ready} !== {em.to, ~em.to} ||
                            (!em.to && {pcpi_wr, pcpi_rd} !== {em.wr, em.rd})) begin
                            n_fail++;
                            $display("FAIL resp act ready=%b to=%b wr=%b rd=%h exp to=%b wr=%b rd=%h",
                                     pcpi_ready, pcpi_timeout, pcpi_wr, pcpi_rd,
                                     em.to, em.wr, em.rd);
                        end
                    end
                end else if (pcpi_rd !== 0 || pcpi_wr !== 0) begin
                    n_fail++;
                    $display("FAIL idle_rd act rd=%h wr=%b exp 0", pcpi_rd, pcpi_wr);
                end
            end
        join_none

        // DIVU 100/7 with a long divider
        run_op(3'd5, 32'd100, 32'd7, 34, 1'b0);

        // unclaimed ADD times out
        es.to = 1'b1;
        es.wr = 1'b0;
        es.rd = '0;
        q_exp.push_back(es);
        pcpi_valid = 1'b1;
        pcpi_insn = 32'h0000_0033;
        step();
        n = 0;
        while (n < 40 && !pcpi_timeout) begin
            step();
            n++;
        end
        chk("timeout_lat", n, TO);
        chk("to_no_ready", 32'(pcpi_ready), 0);
        pcpi_valid = 1'b0;
        step();
        pcpi_valid = 1'b1;
        #1;
        chk("to_idle", 32'(cp_valid), 0);
        pcpi_valid = 1'b0;
        chk("to_sb_empty", q_exp.size(), 0);
        step();

        // conflict: both slots claim together
        c0 = n_conf;
        es.to = 1'b0;
        es.wr = 1'b1;
        es.rd = 32'h1234;
        q_exp.push_back(es);
        pcpi_valid = 1'b1;
        pcpi_insn = mk_insn(3'd4);
        step();
        cp_wait = 2'b11;
        step();
        cp_wait = 2'b01;
        cp_ready = 2'b10;
        cp_wr = 2'b10;
        cp_rd[63:32] = 32'hDEAD;
        step();
        cp_idle();
        cp_wait = 2'b01;
        repeat (3) step();
        cp_idle();
        cp_ready = 2'b01;
        cp_wr = 2'b01;
        cp_rd[31:0] = 32'h1234;
        step();
        cp_idle();
        pcpi_valid = 1'b0;
        step();
        chk("conflict_cnt", 32'(n_conf - c0), 1);
        chk("conf_sb_empty", q_exp.size(), 0);

        // single-cycle multiplier
        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

        // abort after 5 BUSY cycles
        pcpi_valid = 1'b1;
        pcpi_insn = mk_insn(3'd5);
        step();
        cp_wait[0] = 1'b1;
        repeat (5) step();
        pcpi_valid = 1'b0;
        cp_idle();
        #1;
        chk("abort_cp_valid", 32'(cp_valid), 0);
        step();
        step();
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 4, 1'b0);

        // reset mid-BUSY
        pcpi_valid = 1'b1;
        pcpi_insn = mk_insn(3'd4);
        step();
        cp_wait[0] = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_outs", 32'({pcpi_ready, pcpi_wr, pcpi_wait,
                                 pcpi_timeout, pcpi_conflict}), 0);
        chk("mid_rst_rd", pcpi_rd, 0);
        chk("mid_rst_idle", 32'(cp_valid), 0);
        reset = 1'b0;
        pcpi_valid = 1'b0;
        cp_idle();
        cp_ready[0] = 1'b1;
        cp_wr[0] = 1'b1;
        cp_rd[31:0] = 32'hBEEF;
        step();
        chk("late_ready_ignored", 32'(pcpi_ready), 0);
        cp_idle();
        step();

        // randomized traffic with non-owner noise
        for (int k = 0; k < 24; k++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (k == 5) begin
                f3 = 3'd4;
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(f3, a, b, int'($urandom_range(0, 8)), 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("total_conflicts", 32'(n_conf), 1);
        chk("final_sb_empty", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
